// File: rtl/komandara_axi4lite_ram.sv
// AXI4-Lite slave backed by a word-addressed RAM with byte-strobed writes.
// Independent AW/W holding registers feed a write FSM; a separate read FSM runs concurrently.
module komandara_axi4lite_ram #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr_i,
    input  logic [2:0]                s_axi_awprot_i,
    input  logic                      s_axi_awvalid_i,
    output logic                      s_axi_awready_o,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb_i,
    input  logic                      s_axi_wvalid_i,
    output logic                      s_axi_wready_o,
    output logic [1:0]                s_axi_bresp_o,
    output logic                      s_axi_bvalid_o,
    input  logic                      s_axi_bready_i,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr_i,
    input  logic [2:0]                s_axi_arprot_i,
    input  logic                      s_axi_arvalid_i,
    output logic                      s_axi_arready_o,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata_o,
    output logic [1:0]                s_axi_rresp_o,
    output logic                      s_axi_rvalid_o,
    input  logic                      s_axi_rready_i
);
    localparam int unsigned IdxW  = $clog2(DEPTH_WORDS);
    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic {WrCollect, WrResp} wr_state_e;
    typedef enum logic {RdIdle, RdData} rd_state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    wr_state_e             wr_state;
    rd_state_e             rd_state;
    logic                  active;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [StrbW-1:0]      w_strb;
    logic [1:0]            bresp;
    logic [1:0]            rresp;
    logic [DATA_WIDTH-1:0] rdata;

    logic                  aw_fire;
    logic                  w_fire;
    logic                  ar_fire;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [StrbW-1:0]      wr_strb;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  unused_bits;

    // Readies stay low for the cycle after any reset edge.
    assign s_axi_awready_o = active && !aw_held && (wr_state == WrCollect);
    assign s_axi_wready_o  = active && !w_held && (wr_state == WrCollect);
    assign s_axi_arready_o = active && (rd_state == RdIdle);
    assign s_axi_bvalid_o  = (wr_state == WrResp);
    assign s_axi_bresp_o   = bresp;
    assign s_axi_rvalid_o  = (rd_state == RdData);
    assign s_axi_rresp_o   = rresp;
    assign s_axi_rdata_o   = rdata;

    assign unused_bits = ^{s_axi_awprot_i, s_axi_arprot_i, wr_addr[1:0], s_axi_araddr_i[1:0]};

    always_comb begin
        aw_fire     = s_axi_awvalid_i && s_axi_awready_o;
        w_fire      = s_axi_wvalid_i && s_axi_wready_o;
        ar_fire     = s_axi_arvalid_i && s_axi_arready_o;
        wr_addr     = aw_held ? aw_addr : s_axi_awaddr_i;
        wr_data     = w_held ? w_data : s_axi_wdata_i;
        wr_strb     = w_held ? w_strb : s_axi_wstrb_i;
        wr_in_range = (wr_addr >> (IdxW + 2)) == '0;
        rd_in_range = (s_axi_araddr_i >> (IdxW + 2)) == '0;
        // rst_ni gating keeps a capture racing the reset edge from reaching the RAM.
        commit      = rst_ni && (wr_state == WrCollect) &&
                      (aw_held || aw_fire) && (w_held || w_fire);
    end

    always_ff @(posedge clk_i) begin
        active <= rst_ni;
    end

    // RAM contents have no reset and survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (commit && wr_in_range) begin
            for (int b = 0; b < StrbW; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_addr[2 +: IdxW]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_state <= WrCollect;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            bresp    <= RespOkay;
        end else begin
            unique case (wr_state)
                WrCollect: begin
                    if (aw_fire) begin
                        aw_held <= 1'b1;
                        aw_addr <= s_axi_awaddr_i;
                    end
                    if (w_fire) begin
                        w_held <= 1'b1;
                        w_data <= s_axi_wdata_i;
                        w_strb <= s_axi_wstrb_i;
                    end
                    if (commit) begin
                        wr_state <= WrResp;
                        bresp    <= wr_in_range ? RespOkay : RespSlverr;
                    end
                end
                WrResp: begin
                    if (s_axi_bready_i) begin
                        wr_state <= WrCollect;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Reads sample the RAM before a same-edge write lands, so they return old data.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_state <= RdIdle;
            rdata    <= '0;
            rresp    <= RespOkay;
        end else begin
            unique case (rd_state)
                RdIdle: begin
                    if (ar_fire) begin
                        rd_state <= RdData;
                        rdata    <= rd_in_range ? mem[s_axi_araddr_i[2 +: IdxW]] : '0;
                        rresp    <= rd_in_range ? RespOkay : RespSlverr;
                    end
                end
                RdData: begin
                    if (s_axi_rready_i) begin
                        rd_state <= RdIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/komandara_axi4lite_ram.md
KOMANDARA_AXI4LITE_RAM -- requirements
Module: komandara_axi4lite_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width (32 only).
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024, RAM depth in words (power of two).
REQ-004 SHALL use one clock and a synchronous, active-low reset.
REQ-005 SHALL provide these ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- s_axi_awaddr_i  in  ADDR_WIDTH  write address
- s_axi_awprot_i  in  3  ignored
- s_axi_awvalid_i / s_axi_awready_o  in/out  1  AW handshake
- s_axi_wdata_i  in  DATA_WIDTH  write data
- s_axi_wstrb_i  in  DATA_WIDTH/8  byte strobes
- s_axi_wvalid_i / s_axi_wready_o  in/out  1  W handshake
- s_axi_bresp_o  out  2  write response
- s_axi_bvalid_o / s_axi_bready_i  out/in  1  B handshake
- s_axi_araddr_i  in  ADDR_WIDTH  read address
- s_axi_arprot_i  in  3  ignored
- s_axi_arvalid_i / s_axi_arready_o  in/out  1  AR handshake
- s_axi_rdata_o  out  DATA_WIDTH  read data
- s_axi_rresp_o  out  2  read response
- s_axi_rvalid_o / s_axi_rready_i  out/in  1  R handshake

Function
REQ-006 SHALL index RAM by addr[2 +: log2(DEPTH_WORDS)]; addr[1:0] ignored; addr >= 4*DEPTH_WORDS is out of range.
REQ-007 SHALL accept AW and W independently, each into a one-entry holding register; awready_o = !aw_held && !bvalid_o, wready_o = !w_held && !bvalid_o.
REQ-008 Write FSM SHALL have states WR_COLLECT and WR_RESP; on the edge where both AW and W are held (including same-cycle capture of either or both), the RAM write commits and the FSM enters WR_RESP with bvalid_o=1 in the next cycle.
REQ-009 Write commit SHALL update only bytes whose wstrb bit is 1; wstrb=0 commits nothing but still responds OKAY.
REQ-010 Out-of-range write SHALL leave RAM unchanged and return bresp_o=2'b10 (SLVERR); in-range returns 2'b00.
REQ-011 bvalid_o and bresp_o SHALL hold stable until bready_i=1; on that edge the FSM returns to WR_COLLECT and both holding registers clear.
REQ-012 Read FSM SHALL have states RD_IDLE and RD_DATA; arready_o=1 only in RD_IDLE.
REQ-013 On AR handshake, the FSM SHALL register rdata_o/rresp_o and enter RD_DATA, giving rvalid_o=1 exactly one cycle after the handshake.
REQ-014 Out-of-range read SHALL return rdata_o=0 and rresp_o=2'b10.
REQ-015 rvalid_o, rdata_o and rresp_o SHALL hold stable until rready_i=1, then return to RD_IDLE; sustained read throughput is one per two cycles.
REQ-016 Read and write paths SHALL operate concurrently; when an AR handshake and a write commit to the same word occur on the same edge, the read SHALL return pre-write data.
REQ-017 awprot/arprot SHALL have no effect; RAM contents SHALL not be initialised.

Reset
REQ-018 While rst_ni=0 at a clock edge, the block SHALL drive awready_o=wready_o=arready_o=0, bvalid_o=rvalid_o=0, bresp_o=rresp_o=0 and rdata_o=0 from the next cycle.
REQ-019 Reset SHALL return both FSMs to WR_COLLECT/RD_IDLE and discard held AW/W without committing them; RAM contents SHALL be preserved.
REQ-020 Ready outputs SHALL be 1 in the first cycle after rst_ni rises.

Verification
REQ-021 AW and W in the same cycle to 0x0 with 0xCAFEBABE and strb 0xF -> bvalid 1 cycle later with OKAY; read of 0x0 -> 0xCAFEBABE with OKAY, rvalid 1 cycle after AR.
REQ-022 W 3 cycles before AW (0x10, 0x11223344), then strobe-0x5 write of 0xAABBCCDD to 0x10 -> read of 0x10 returns 0x11BB33DD.
REQ-023 Write and read to 0x1000 (DEPTH 1024) -> bresp and rresp 2'b10, rdata 0, and RAM word 0 unchanged.
REQ-024 bready and rready held low 5 cycles -> bvalid/rvalid and data stay stable, awready/wready/arready stay 0, and no second transaction is accepted.
REQ-025 Write of 0x5 to 0x8 committing on the same edge as an AR to 0x8 (old 0x1) -> read returns 0x1, and a subsequent read returns 0x5.
REQ-026 AW held (0x4, 0xDEAD) with W pending, then reset asserted -> after reset, a read of 0x4 returns the prior value and no B response appears.
